// File: rtl/pcie_cfg_mgmt_arbiter_if.sv
// Bundle of requester-side and core-side signals around the PCIe
// configuration management arbiter. The slave modport is the arbiter's
// view; the master modport is the view of whatever drives requests and
// models the PCIe core.
interface pcie_cfg_mgmt_arbiter_if #(
  parameter int PORTS = 4
);
  logic [PORTS-1:0]    s_req_valid;
  logic [PORTS-1:0]    s_req_ready;
  logic [PORTS-1:0]    s_req_write;
  logic [PORTS*10-1:0] s_req_addr;
  logic [PORTS*8-1:0]  s_req_function_number;
  logic [PORTS*32-1:0] s_req_write_data;
  logic [PORTS*4-1:0]  s_req_byte_enable;
  logic [PORTS-1:0]    s_resp_valid;
  logic [31:0]         s_resp_data;
  logic                s_resp_error;

  logic [9:0]          cfg_mgmt_addr;
  logic [7:0]          cfg_mgmt_function_number;
  logic                cfg_mgmt_write;
  logic [31:0]         cfg_mgmt_write_data;
  logic [3:0]          cfg_mgmt_byte_enable;
  logic                cfg_mgmt_read;
  logic [31:0]         cfg_mgmt_read_data;
  logic                cfg_mgmt_read_write_done;

  modport slave (
    input  s_req_valid, s_req_write, s_req_addr, s_req_function_number,
           s_req_write_data, s_req_byte_enable,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    output s_req_ready, s_resp_valid, s_resp_data, s_resp_error,
           cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read
  );

  modport master (
    output s_req_valid, s_req_write, s_req_addr, s_req_function_number,
           s_req_write_data, s_req_byte_enable,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    input  s_req_ready, s_resp_valid, s_resp_data, s_resp_error,
           cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read
  );
endinterface

// File: rtl/pcie_cfg_mgmt_arbiter.sv
// Round-robin arbiter sharing the PCIe hard-IP cfg_mgmt port among PORTS
// requesters. One read or write is in flight at a time; the strobe is held
// until the core reports done or the timeout counter expires, and the
// result is returned as a one-cycle response to the owning requester.
// Every output is a register. The response cycle coincides with the
// return to IDLE so the next arbitration can already happen during it,
// giving a 3-cycle minimum turnaround.
module pcie_cfg_mgmt_arbiter #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic                    clk,
  input logic                    rst_n,
  pcie_cfg_mgmt_arbiter_if.slave bus
);
  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ACCEPT is the cycle the ready pulse is visible; ISSUE covers exactly
  // the cycles with a strobe high.
  typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] win, win_after;
  logic             any_req;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_write, op_write_nxt;
  logic             done_hit, expire;

  logic [PORTS-1:0] ready, ready_nxt;
  logic [PORTS-1:0] resp_valid, resp_valid_nxt;
  logic [31:0]      resp_data, resp_data_nxt;
  logic             resp_error, resp_error_nxt;
  logic [9:0]       addr, addr_nxt;
  logic [7:0]       fn, fn_nxt;
  logic [31:0]      wdata, wdata_nxt;
  logic [3:0]       be, be_nxt;
  logic             mgmt_write, mgmt_write_nxt;
  logic             mgmt_read, mgmt_read_nxt;

  // Pick the first pending requester at or after the pointer, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!any_req && bus.s_req_valid[(int'(ptr) + i) % PORTS]) begin
        any_req = 1'b1;
        win     = PTR_W'((int'(ptr) + i) % PORTS);
      end
    end
  end

  assign win_after = (int'(win) == PORTS - 1) ? '0 : PTR_W'(int'(win) + 1);

  // Done is only meaningful while a strobe is out; done beats expiry.
  assign done_hit = (state == ISSUE) && bus.cfg_mgmt_read_write_done;
  assign expire   = (state == ISSUE) && (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCEPT;
      ACCEPT:  state_nxt = ISSUE;
      ISSUE:   if (done_hit || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    ptr_nxt        = ptr;
    owner_nxt      = owner;
    op_write_nxt   = op_write;
    addr_nxt       = addr;
    fn_nxt         = fn;
    wdata_nxt      = wdata;
    be_nxt         = be;
    resp_data_nxt  = resp_data;
    resp_error_nxt = resp_error;
    ready_nxt      = '0;
    resp_valid_nxt = '0;
    mgmt_write_nxt = 1'b0;
    mgmt_read_nxt  = 1'b0;
    cnt_nxt        = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          ready_nxt[win] = 1'b1;
          owner_nxt      = win;
          ptr_nxt        = win_after;
          op_write_nxt   = bus.s_req_write[win];
          addr_nxt       = bus.s_req_addr[int'(win)*10 +: 10];
          fn_nxt         = bus.s_req_function_number[int'(win)*8 +: 8];
          wdata_nxt      = bus.s_req_write_data[int'(win)*32 +: 32];
          be_nxt         = bus.s_req_byte_enable[int'(win)*4 +: 4];
        end
      end
      ACCEPT: begin
        mgmt_write_nxt = op_write;
        mgmt_read_nxt  = ~op_write;
        cnt_nxt        = CNT_ONE;
      end
      ISSUE: begin
        if (done_hit) begin
          resp_valid_nxt[owner] = 1'b1;
          resp_data_nxt         = bus.cfg_mgmt_read_data;
          resp_error_nxt        = 1'b0;
        end else if (expire) begin
          resp_valid_nxt[owner] = 1'b1;
          resp_data_nxt         = '0;
          resp_error_nxt        = 1'b1;
        end else begin
          mgmt_write_nxt = op_write;
          mgmt_read_nxt  = ~op_write;
          cnt_nxt        = cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      op_write   <= 1'b0;
      cnt        <= '0;
      ready      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      addr       <= '0;
      fn         <= '0;
      wdata      <= '0;
      be         <= '0;
      mgmt_write <= 1'b0;
      mgmt_read  <= 1'b0;
    end else begin
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      op_write   <= op_write_nxt;
      cnt        <= cnt_nxt;
      ready      <= ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_data  <= resp_data_nxt;
      resp_error <= resp_error_nxt;
      addr       <= addr_nxt;
      fn         <= fn_nxt;
      wdata      <= wdata_nxt;
      be         <= be_nxt;
      mgmt_write <= mgmt_write_nxt;
      mgmt_read  <= mgmt_read_nxt;
    end
  end

  assign bus.s_req_ready              = ready;
  assign bus.s_resp_valid             = resp_valid;
  assign bus.s_resp_data              = resp_data;
  assign bus.s_resp_error             = resp_error;
  assign bus.cfg_mgmt_addr            = addr;
  assign bus.cfg_mgmt_function_number = fn;
  assign bus.cfg_mgmt_write           = mgmt_write;
  assign bus.cfg_mgmt_write_data      = wdata;
  assign bus.cfg_mgmt_byte_enable     = be;
  assign bus.cfg_mgmt_read            = mgmt_read;
endmodule

// File: tb/tb_pcie_cfg_mgmt_arbiter.sv
// Bench for pcie_cfg_mgmt_arbiter: requesters and a PCIe core model
// driven at the falling edge, outputs sampled at the falling edge, and
// expectations taken from a transaction-level model (pending set,
// round-robin pointer, expected strobe length and turnaround).
module tb_pcie_cfg_mgmt_arbiter;
  localparam int PORTS   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcie_cfg_mgmt_arbiter_if #(.PORTS(PORTS)) bus();

  pcie_cfg_mgmt_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Requester model state.
  logic [PORTS-1:0] pending;
  logic             req_wr   [PORTS];
  logic [9:0]       req_addr [PORTS];
  logic [7:0]       req_fn   [PORTS];
  logic [31:0]      req_wd   [PORTS];
  logic [3:0]       req_be   [PORTS];
  int               ptr_m;
  int               last_accept;
  int               last_n;
  bit               chain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PORTS-1:0] onehot(input int p);
    logic [PORTS-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [PORTS-1:0] m, input int ptr);
    for (int i = 0; i < PORTS; i++)
      if (m[(ptr + i) % PORTS]) return (ptr + i) % PORTS;
    return -1;
  endfunction

  task automatic drive_reqs(input logic [PORTS-1:0] ghost);
    bus.s_req_valid = pending | ghost;
    for (int i = 0; i < PORTS; i++) begin
      bus.s_req_write[i]                   = req_wr[i];
      bus.s_req_addr[i*10 +: 10]           = req_addr[i];
      bus.s_req_function_number[i*8 +: 8]  = req_fn[i];
      bus.s_req_write_data[i*32 +: 32]     = req_wd[i];
      bus.s_req_byte_enable[i*4 +: 4]      = req_be[i];
    end
  endtask

  task automatic rand_fields(input int p);
    req_wr[p]   = 1'($urandom_range(0, 1));
    req_addr[p] = 10'($urandom);
    req_fn[p]   = 8'($urandom);
    req_wd[p]   = $urandom;
    req_be[p]   = 4'($urandom);
  endtask

  task automatic set_req(input int p, input logic w, input logic [9:0] a,
                         input logic [7:0] f, input logic [31:0] d, input logic [3:0] b);
    pending[p]  = 1'b1;
    req_wr[p]   = w;
    req_addr[p] = a;
    req_fn[p]   = f;
    req_wd[p]   = d;
    req_be[p]   = b;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_hs"}, {bus.s_req_ready, bus.s_resp_valid, bus.s_resp_error,
                       bus.cfg_mgmt_write, bus.cfg_mgmt_read}, '0);
    chk({tag, "_data"}, {bus.s_resp_data, bus.cfg_mgmt_write_data}, '0);
    chk({tag, "_fields"}, {bus.cfg_mgmt_addr, bus.cfg_mgmt_function_number,
                           bus.cfg_mgmt_byte_enable}, '0);
  endtask

  task automatic idle(input int n);
    drive_reqs('0);
    repeat (n) begin
      @(negedge clk);
      bus.cfg_mgmt_read_write_done = 1'b0;
    end
    chain = 1'b0;
  endtask

  // One arbitration round over the current pending set. lat = strobe cycle
  // on which the core answers (0 = never); rst_at = strobe cycle on which
  // reset is asserted (0 = never).
  task automatic txn(input int lat, input logic [31:0] rdata, input int rst_at);
    int          win;
    int          n;
    int          n_exp;
    int          field_bad;
    bit          answered;
    logic        exp_wr;
    logic [53:0] exp_f;
    logic [PORTS-1:0] stale;
    drive_reqs('0);
    win = pick(pending, ptr_m);
    if (win < 0) begin
      @(negedge clk);
      bus.cfg_mgmt_read_write_done = 1'b0;
      chain = 1'b0;
      return;
    end
    exp_wr = req_wr[win];
    exp_f  = {req_addr[win], req_fn[win], req_wd[win], req_be[win]};

    @(negedge clk);
    bus.cfg_mgmt_read_write_done = 1'b0;
    chk("ready", bus.s_req_ready, onehot(win));
    chk("resp_idle", bus.s_resp_valid, '0);
    chk("strobe_at_accept", {bus.cfg_mgmt_write, bus.cfg_mgmt_read}, 2'b00);
    if (chain) chk("turnaround", cyc - last_accept, last_n + 2);
    last_accept = cyc;
    ptr_m = (win + 1) % PORTS;
    pending[win] = 1'b0;
    rand_fields(win);
    drive_reqs(PORTS'($urandom));

    answered = (lat >= 1) && (lat <= TIMEOUT);
    n_exp    = answered ? lat : TIMEOUT;
    n        = 0;
    field_bad = 0;
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      @(negedge clk);
      bus.cfg_mgmt_read_write_done = 1'b0;
      if (!bus.cfg_mgmt_write && !bus.cfg_mgmt_read) break;
      n++;
      if ({bus.cfg_mgmt_write, bus.cfg_mgmt_read} != {exp_wr, ~exp_wr}) field_bad++;
      if ({bus.cfg_mgmt_addr, bus.cfg_mgmt_function_number, bus.cfg_mgmt_write_data,
           bus.cfg_mgmt_byte_enable} != exp_f) field_bad++;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_issue");
        pending = '0;
        drive_reqs('0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        chain = 1'b0;
        stale = '0;
        repeat (3) begin
          @(negedge clk);
          stale = stale | bus.s_resp_valid | bus.s_req_ready
                | {{(PORTS-2){1'b0}}, bus.cfg_mgmt_write, bus.cfg_mgmt_read};
        end
        chk("post_reset_quiet", stale, '0);
        return;
      end
      drive_reqs(PORTS'($urandom));
      if (k == lat) begin
        bus.cfg_mgmt_read_write_done = 1'b1;
        bus.cfg_mgmt_read_data       = rdata;
      end else begin
        bus.cfg_mgmt_read_data       = $urandom;
      end
    end
    chk("strobe_cycles", n, n_exp);
    chk("fields_stable", field_bad, 0);
    chk("resp_valid", bus.s_resp_valid, onehot(win));
    chk("resp_data", bus.s_resp_data, answered ? rdata : 32'h0);
    chk("resp_error", bus.s_resp_error, answered ? 1'b0 : 1'b1);
    last_n = n_exp;
    chain  = 1'b1;
    drive_reqs('0);
    // Late/spurious done while no strobe is out must be ignored.
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data       = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pending = '0;
    for (int i = 0; i < PORTS; i++) begin
      req_wr[i] = 1'b0; req_addr[i] = '0; req_fn[i] = '0; req_wd[i] = '0; req_be[i] = '0;
    end
    bus.s_req_valid = '0;
    bus.s_req_write = '0;
    bus.s_req_addr = '0;
    bus.s_req_function_number = '0;
    bus.s_req_write_data = '0;
    bus.s_req_byte_enable = '0;
    bus.cfg_mgmt_read_data = '0;
    bus.cfg_mgmt_read_write_done = 1'b0;
    ptr_m = 0; chain = 1'b0; last_accept = 0; last_n = 0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Single read from port 2.
    set_req(2, 1'b0, 10'h004, 8'h00, $urandom, 4'($urandom));
    txn(3, 32'h10EE9038, 0);

    // Write from port 0.
    set_req(0, 1'b1, 10'h013, 8'h00, 32'hDEADBEEF, 4'hF);
    txn(2, $urandom, 0);

    // All ports requesting continuously, core answers on first strobe.
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < PORTS; p++)
        if (!pending[p]) begin rand_fields(p); pending[p] = 1'b1; end
      txn(1, $urandom, 0);
    end
    pending = '0;
    idle(2);

    // No answer: timeout, then a late done in the response cycle.
    rand_fields(1); pending[1] = 1'b1;
    txn(0, $urandom, 0);
    // Done on the very last strobe cycle wins over expiry.
    rand_fields(3); pending[3] = 1'b1;
    txn(TIMEOUT, $urandom, 0);

    // Reset while a read is out; pointer left non-zero beforehand.
    set_req(2, 1'b0, 10'($urandom), 8'($urandom), $urandom, 4'($urandom));
    txn(5, $urandom, 2);
    for (int p = 0; p < PORTS; p++) begin rand_fields(p); pending[p] = 1'b1; end
    txn(1, $urandom, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if (pending == '0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      for (int p = 0; p < PORTS; p++)
        if (!pending[p] && $urandom_range(0, 1) == 1) begin rand_fields(p); pending[p] = 1'b1; end
      txn($urandom_range(0, TIMEOUT + 1), $urandom, 0);
    end
    pending = '0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcie_cfg_mgmt_arbiter.md
# pcie_cfg_mgmt_arbiter

Shares the single PCIe hard-IP configuration management port (cfg_mgmt_*) among PORTS requesters, such as driver-visible register bridges and MSI/capability setup logic. Uses round-robin arbitration and runs exactly one config read or write at a time. Holds the strobe until the core signals completion, returns read data and status to the winning requester, and aborts with an error if the core does not answer. Sits between fpga_core-level requesters and the cfg_mgmt_* ports of the UltraScale+ PCIe core, in the PCIe user clock domain.

## Interface

Parameters:
- PORTS, 4, number of requesters (1-16).
- TIMEOUT, 1023, maximum strobe cycles before abort (≥1); counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  PCIe user clock (250 MHz).
- rst_n  in  1  reset; asynchronous assert, active-low.
- s_req_valid  in  PORTS  request pending, held until s_req_ready.
- s_req_ready  out  PORTS  one-hot, 1-cycle accept pulse.
- s_req_write  in  PORTS  1 = write, 0 = read.
- s_req_addr  in  PORTS*10  DWORD address, port i at [i*10 +: 10].
- s_req_function_number  in  PORTS*8  target function.
- s_req_write_data  in  PORTS*32  write data.
- s_req_byte_enable  in  PORTS*4  write byte enables.
- s_resp_valid  out  PORTS  one-hot, 1-cycle completion pulse.
- s_resp_data  out  32  read data, shared, valid with s_resp_valid.
- s_resp_error  out  1  timeout flag, shared, valid with s_resp_valid.
- cfg_mgmt_addr  out  10  to core.
- cfg_mgmt_function_number  out  8  to core.
- cfg_mgmt_write  out  1  to core.
- cfg_mgmt_write_data  out  32  to core.
- cfg_mgmt_byte_enable  out  4  to core.
- cfg_mgmt_read  out  1  to core.
- cfg_mgmt_read_data  in  32  from core.
- cfg_mgmt_read_write_done  in  1  from core.

## Operation

- **Reset values.** All outputs are registered and reset to 0. State = IDLE, grant pointer = 0, timeout counter = 0.
- **IDLE.**
  - If any s_req_valid is set, pick the first set bit at or after the pointer, wrapping modulo PORTS.
  - Pulse that port's s_req_ready. Latch its addr, function, data, byte enable and write bit onto the cfg_mgmt_* outputs.
  - Set pointer = (winner+1) mod PORTS and go to ISSUE.
- **ISSUE.**
  - cfg_mgmt_write = latched write bit; cfg_mgmt_read = its inverse. Exactly one is high.
  - All cfg_mgmt_* fields stay stable for the whole state.
  - The counter increments each cycle.
  - On cfg_mgmt_read_write_done:
    - capture cfg_mgmt_read_data into s_resp_data (captured for writes too);
    - s_resp_error = 0;
    - go to RESP.
  - Else, when the counter reaches TIMEOUT: s_resp_data = 0, s_resp_error = 1, go to RESP.
  - If done and counter expiry fall in the same cycle, done wins.
- **RESP.**
  - Strobes are low.
  - Pulse s_resp_valid for the owning port for one cycle.
  - Clear the counter and return to IDLE.
- **Spurious done.** cfg_mgmt_read_write_done outside ISSUE is ignored.
- **Ignored inputs.** Request fields are sampled only at accept. s_req_valid dropping before ready is tolerated and is simply not granted.
- **Reset mid-operation.** Asserting rst_n low forces strobes low immediately. The in-flight transaction produces no response.

## Timing

- Accept at cycle A. Strobe is high from A+1.
- Done seen at cycle D (D ≥ A+1):
  - strobe is low at D+1;
  - s_resp_valid and s_resp_data are valid at D+1;
  - next accept is possible at D+2;
  - next strobe is at D+3.
- The strobe is therefore low for at least 2 cycles between transactions. This meets the core's deassert-after-done rule.
- Minimum turnaround is 3 cycles per transaction when done arrives on the first strobe cycle.
- Timeout:
  - counter value k during the k-th strobe cycle (k = 1..TIMEOUT);
  - with no done, strobe drops and the error response is at A+TIMEOUT+1.
- Fairness: with all ports requesting continuously, each port is granted once every PORTS transactions.

## Test plan

- **Single read.** Port 2 reads addr 0x004, fn 0. Core returns done + data 0x10EE9038 on the 3rd strobe cycle. Expect:
  - ready[2] at A;
  - cfg_mgmt_read high for 3 cycles;
  - resp_valid[2] with data 0x10EE9038, error 0 one cycle after done.
- **Write.** Port 0 writes addr 0x013, data 0xDEADBEEF, be 0xF. Expect cfg_mgmt_write high with stable fields until done, then resp_valid[0] with error 0.
- **Round robin.** All 4 ports request continuously with done on the first strobe cycle. Expect grant order 0,1,2,3,0,… with exactly 3 cycles between successive accepts.
- **Timeout.** TIMEOUT=8, no done. Expect the strobe high for exactly 8 cycles, then resp_valid with error 1 and data 0. A late done the following cycle is ignored.
- **Done/timeout collision.** Done arrives on strobe cycle TIMEOUT. Expect error 0 and the captured data returned.
- **Async reset mid-ISSUE.** Assert rst_n low while cfg_mgmt_read is high. Expect all outputs 0 without waiting for a clock edge. After release, expect the pointer at port 0 and no stale resp_valid.
